// File: rtl/fpu_pkg.sv
// Shared FPU package: operand field widths, special-exponent encoding and the
// denormalizer state type. Also used by the normalizer and the multiplier top.
package fpu_pkg;

    localparam int FRAC_W = 23;                 // stored fraction width
    localparam int EXP_W  = 8;                  // biased exponent width
    localparam int WORK_W = FRAC_W + 3;         // hidden bit + fraction + guard/round slots
    localparam int CNT_W  = 5;                  // holds shift counts 1..25

    localparam logic [8:0]       SAT_SHIFT   = 9'd26;   // shift count that empties the work register
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;   // Inf/NaN exponent

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } denorm_state_t;

    // 9-bit unsigned difference target - exponent; bit 8 set means target < exponent.
    function automatic logic [8:0] exp_diff(input logic [EXP_W-1:0] target,
                                            input logic [EXP_W-1:0] exponent);
        return {1'b0, target} - {1'b0, exponent};
    endfunction

endpackage

// File: rtl/sticky_shift_reg.sv
// 26-bit right-shift register with sticky accumulation.
// Ports: load_i/load_data_i load a new work value and clear sticky;
//        sat_i clears the work value and sets sticky to sat_sticky_i;
//        shift_i shifts right by one, ORing the dropped LSB into sticky;
//        work_o/sticky_o are the registered state.
module sticky_shift_reg
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WORK_W-1:0] load_data_i,
    input  logic              sat_i,
    input  logic              sat_sticky_i,
    input  logic              shift_i,
    output logic [WORK_W-1:0] work_o,
    output logic              sticky_o
);

    logic [WORK_W-1:0] work_q, work_d;
    logic              sticky_q, sticky_d;

    // Next-state selection: load beats saturate beats shift; otherwise hold.
    always_comb begin
        work_d   = work_q;
        sticky_d = sticky_q;
        if (load_i) begin
            work_d   = load_data_i;
            sticky_d = 1'b0;
        end else if (sat_i) begin
            work_d   = '0;
            sticky_d = sat_sticky_i;
        end else if (shift_i) begin
            work_d   = {1'b0, work_q[WORK_W-1:1]};
            sticky_d = sticky_q | work_q[0];
        end else begin
            work_d   = work_q;
            sticky_d = sticky_q;
        end
    end

    // Work and sticky registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            work_q   <= work_d;
            sticky_q <= sticky_d;
        end
    end

    assign work_o   = work_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/denormalization_machine.sv
// Multi-cycle right-shift aligner. Accepts a normalized single-precision
// operand plus a target exponent, expands the hidden bit and shifts the
// fraction right one bit per cycle until the exponent matches the target,
// collecting guard/round/sticky.
// Ports: in_valid/in_ready input handshake; sign/fraction/exponent operand;
//        target_exponent alignment target; out_valid/out_ready output
//        handshake; out_sign/out_fraction/out_exponent result;
//        guard/round_bit/sticky shifted-out bits; misalign flags
//        target_exponent < exponent (no shift performed).
module denormalization_machine
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [FRAC_W-1:0] fraction,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [EXP_W-1:0]  target_exponent,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [FRAC_W:0]   out_fraction,
    output logic [EXP_W-1:0]  out_exponent,
    output logic              guard,
    output logic              round_bit,
    output logic              sticky,
    output logic              misalign
);

    denorm_state_t     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_sign_q, out_sign_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic              misalign_q, misalign_d;

    logic              accept_s;
    logic              special_s;
    logic              misalign_s;
    logic              hidden_s;
    logic              sat_s;
    logic [8:0]        diff_s;
    logic [8:0]        k_s;
    logic [WORK_W-1:0] work_s;

    // Accept-time classification. Inf/NaN takes priority over misalign.
    assign accept_s   = (state_q == IDLE) && in_valid;
    assign diff_s     = exp_diff(target_exponent, exponent);
    assign special_s  = (exponent == EXP_SPECIAL);
    assign misalign_s = !special_s && diff_s[8];
    assign k_s        = (special_s || misalign_s) ? 9'd0 : diff_s;
    assign sat_s      = (k_s >= SAT_SHIFT);
    assign hidden_s   = (exponent != 8'd0);

    sticky_shift_reg u_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (accept_s && !sat_s),
        .load_data_i  ({hidden_s, fraction, 2'b00}),
        .sat_i        (accept_s && sat_s),
        .sat_sticky_i (hidden_s | (|fraction)),
        .shift_i      (state_q == SHIFT),
        .work_o       (work_s),
        .sticky_o     (sticky)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if ((k_s == 9'd0) || sat_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (count_q == 5'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Shift counter and result-field next values; captured on accept.
    always_comb begin
        count_d    = count_q;
        out_sign_d = out_sign_q;
        out_exp_d  = out_exp_q;
        misalign_d = misalign_q;
        if (accept_s) begin
            count_d    = k_s[CNT_W-1:0];  // only meaningful when 1 <= k <= 25
            out_sign_d = sign;
            misalign_d = misalign_s;
            if (special_s) begin
                out_exp_d = EXP_SPECIAL;
            end else if (misalign_s) begin
                out_exp_d = exponent;
            end else begin
                out_exp_d = target_exponent;
            end
        end else if (state_q == SHIFT) begin
            count_d = count_q - 5'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter and result-field registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            out_sign_q <= 1'b0;
            out_exp_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            out_sign_q <= out_sign_d;
            out_exp_q  <= out_exp_d;
            misalign_q <= misalign_d;
        end
    end

    assign out_sign     = out_sign_q;
    assign out_exponent = out_exp_q;
    assign misalign     = misalign_q;
    assign out_fraction = work_s[WORK_W-1:2];
    assign guard        = work_s[1];
    assign round_bit    = work_s[0];

endmodule
